// File: rtl/seq_110_framer_tx.sv
// Serial framer for the "110" detection link: preamble 1,1,0 then a zero-stuffed payload, MSB first.
// Optional even-parity trailer is enabled by defining SEQ_110_TX_PARITY_EN.
module seq_110_framer_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             x_out,
  output logic             tx_active,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ALL_SENT = CW'(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PRE1,
    PRE2,
    PRE3,
    DATA,
    STUFF
`ifdef SEQ_110_TX_PARITY_EN
    ,
    PAR,
    PSTUFF
`endif
  } state_t;

  state_t           state_q, state_d;
  state_t           end_state;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             done_q, done_d;
  logic             accept;

`ifdef SEQ_110_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  assign accept = valid_in && (state_q == IDLE);

`ifdef SEQ_110_TX_PARITY_EN
  assign end_state = PAR;
`else
  assign end_state = IDLE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_110_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      done_q  <= done_d;
`ifdef SEQ_110_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // state_q names the bit currently on the line; cnt_q counts payload bits already sent.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef SEQ_110_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = PRE1;
          shift_d = data_in;
          cnt_d   = '0;
`ifdef SEQ_110_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      PRE1: state_d = PRE2;
      PRE2: state_d = PRE3;
      PRE3: state_d = DATA;
      DATA: begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (shift_q[WIDTH-1]) begin
          state_d = STUFF;
        end else if (cnt_q == LAST_IDX) begin
          state_d = end_state;
        end else begin
          state_d = DATA;
        end
      end
      STUFF: begin
        if (cnt_q == ALL_SENT) begin
          state_d = end_state;
        end else begin
          state_d = DATA;
        end
      end
`ifdef SEQ_110_TX_PARITY_EN
      PAR: begin
        if (parity_q) begin
          state_d = PSTUFF;
        end else begin
          state_d = IDLE;
        end
      end
      PSTUFF: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Line and done are registered, so they are decoded from the state being entered.
  always_comb begin
    x_d    = 1'b0;
    done_d = 1'b0;
    case (state_d)
      PRE1, PRE2: x_d = 1'b1;
      DATA: begin
        x_d = shift_d[WIDTH-1];
`ifndef SEQ_110_TX_PARITY_EN
        done_d = !shift_d[WIDTH-1] && (cnt_d == LAST_IDX);
`endif
      end
      STUFF: begin
`ifndef SEQ_110_TX_PARITY_EN
        done_d = (cnt_d == ALL_SENT);
`endif
      end
`ifdef SEQ_110_TX_PARITY_EN
      PAR: begin
        x_d    = parity_d;
        done_d = !parity_d;
      end
      PSTUFF: done_d = 1'b1;
`endif
      default: begin
        x_d    = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign x_out      = x_q;
  assign frame_done = done_q;
  assign ready_out  = (state_q == IDLE);
  assign tx_active  = (state_q != IDLE);

endmodule
